// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared types and constants for the UART command master.
// Frame layout on the wire: {cmd, addr, data_hi, data_lo}; responses start with RSP_HEADER.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_TX,
        RESP,
        DONE
    } state_t;

    localparam logic [7:0] RSP_HEADER    = 8'hFF;
    localparam int         CMD_WRITE_BIT = 0;
    localparam int         FRAME_BYTES   = 4;
    localparam int         IDX_W         = 2;

    // Command byte: all zero except the write flag.
    function automatic logic [7:0] cmd_byte(input logic write);
        logic [7:0] b;
        b                = '0;
        b[CMD_WRITE_BIT] = write;
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_rsp_parser.sv
// uart_cmd_rsp_parser: collects the 4-byte read response {0xFF, addr, data_hi, data_lo}.
// Hunts for the header (discarding anything else), assembles the data word and
// times out when the line stays silent for TIMEOUT_CYCLES clocks.
// Build option: UART_CMD_ADDR_CHECK_EN compares the echoed address with exp_addr.
module uart_cmd_rsp_parser
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte,
    input  logic [7:0]  exp_addr,
    output logic        done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        timeout
);

    logic                 active;
    logic                 hdr_seen;
    logic [1:0]           bcnt;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [7:0]           data_hi;
    logic                 byte_done;
    logic                 tmo;

    // The last data byte and the timeout both finish the response; rx activity wins a tie.
    assign byte_done = active && rx_dv && hdr_seen && (bcnt == 2'd2);
    assign tmo       = active && !rx_dv && (tcnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
    assign done      = byte_done || tmo;
    assign timeout   = tmo;
    assign rdata     = byte_done ? {data_hi, rx_byte} : 16'h0000;

`ifdef UART_CMD_ADDR_CHECK_EN
    logic addr_bad;

    assign err = byte_done && addr_bad;

    // Remember whether the echoed address disagreed with the one we sent.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_bad <= 1'b0;
        end else if (start) begin
            addr_bad <= 1'b0;
        end else if (active && rx_dv && hdr_seen && (bcnt == 2'd0)) begin
            addr_bad <= (rx_byte != exp_addr);
        end
    end
`else
    logic unused_exp_addr;

    assign unused_exp_addr = ^exp_addr;
    assign err             = 1'b0;
`endif

    // Header hunt, data-phase byte counter and silence timer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active   <= 1'b0;
            hdr_seen <= 1'b0;
            bcnt     <= 2'd0;
            tcnt     <= '0;
        end else if (start) begin
            active   <= 1'b1;
            hdr_seen <= 1'b0;
            bcnt     <= 2'd0;
            tcnt     <= '0;
        end else if (active) begin
            if (done) begin
                active <= 1'b0;
            end
            if (rx_dv) begin
                tcnt <= '0;
                if (!hdr_seen) begin
                    hdr_seen <= (rx_byte == RSP_HEADER);
                end else begin
                    bcnt <= bcnt + 2'd1;
                end
            end else begin
                tcnt <= tcnt + 1'b1;
            end
        end
    end

    // High data byte is held until the low byte arrives; no reset needed.
    always_ff @(posedge clk) begin
        if (active && rx_dv && hdr_seen && (bcnt == 2'd1)) begin
            data_hi <= rx_byte;
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: host-side initiator for the 4-byte UART register protocol.
// Sends {cmd, addr, data_hi, data_lo} through a byte-wide UART transmitter and,
// for reads, waits for the {0xFF, addr, data_hi, data_lo} response.
// Build option: UART_CMD_ADDR_CHECK_EN enables response address checking (in the parser).
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_W      = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    input  logic        tx_done,
    input  logic        rx_dv,
    input  logic [7:0]  rx_byte
);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             write_q;
    logic [7:0]       addr_q;
    logic [15:0]      wdata_q;
    logic             last_byte;
    logic             p_start;
    logic             p_done;
    logic [15:0]      p_rdata;
    logic             p_err;
    logic             p_timeout;

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i, input logic wr,
                                              input logic [7:0] a, input logic [15:0] d);
        case (i)
            2'd0:    return cmd_byte(wr);
            2'd1:    return a;
            2'd2:    return d[15:8];
            default: return d[7:0];
        endcase
    endfunction

    assign last_byte = (idx == IDX_W'(FRAME_BYTES - 1));
    assign p_start   = (state == WAIT_TX) && tx_done && last_byte && !write_q;

    uart_cmd_rsp_parser #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_parser (
        .clk      (clk),
        .rst      (rst),
        .start    (p_start),
        .rx_dv    (rx_dv),
        .rx_byte  (rx_byte),
        .exp_addr (addr_q),
        .done     (p_done),
        .rdata    (p_rdata),
        .err      (p_err),
        .timeout  (p_timeout)
    );

    // Request/frame sequencer with registered handshake and UART strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 16'h0000;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            tx_start    <= 1'b0;
            tx_byte     <= 8'h00;
            idx         <= '0;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_write ? req_wdata : 16'h0000;
                        idx       <= '0;
                        req_ready <= 1'b0;
                        tx_start  <= 1'b1;
                        tx_byte   <= cmd_byte(req_write);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    state    <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (tx_done) begin
                        if (!last_byte) begin
                            idx      <= idx + 1'b1;
                            tx_byte  <= frame_byte(idx + 1'b1, write_q, addr_q, wdata_q);
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end else if (write_q) begin
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= 16'h0000;
                            rsp_err     <= 1'b0;
                            rsp_timeout <= 1'b0;
                            state       <= DONE;
                        end else begin
                            idx   <= '0;
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (p_done) begin
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= p_rdata;
                        rsp_err     <= p_err;
                        rsp_timeout <= p_timeout;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid   <= 1'b0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
